instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch unit: FETCH/WAIT/EXEC/HALT sequencing, PC update
// (sequential, branch, jump), fetch timeout fault and retired-instruction count.
module instr_fetch #(
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        PCwrt,
  input  logic        jump,
  input  logic        branch,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic        capture, retire, cnt_inc, to_fault;
  logic [31:0] br_off, br_target, j_target, next_pc;

  assign pc4       = pc + 32'd4;
  assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign br_target = pc4 + br_off;
  assign j_target  = {pc4[31:28], instr[25:0], 2'b00};
  // Branch takes priority over jump when the controller asserts both.
  assign next_pc   = branch ? br_target : (jump ? j_target : pc4);

  assign imem_addr = pc;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign halted    = (state == S_HALT);

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    retire      = 1'b0;
    cnt_inc     = 1'b0;
    to_fault    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Ready arriving in the expiry cycle still wins over the timeout.
        if (imem_ready) begin
          capture    = 1'b1;
          state_next = S_EXEC;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          to_fault   = 1'b1;
          state_next = S_HALT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          if (PCwrt) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_HALT;
          end
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
    if (Reset) begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc       <= RESET_PC;
      instr    <= '0;
      retired  <= '0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (state == S_FETCH) wait_cnt <= '0;
      else if (cnt_inc)     wait_cnt <= wait_cnt + 8'd1;
      if (capture)  instr <= imem_rdata;
      if (to_fault) fault <= 1'b1;
      if (retire) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule
